controlador_memoria: RTL

Load/store sequencer that acts as the initiator on the data-memory port: it accepts single load/store requests from the datapath over a valid/ready handshake. It then drives `Endereco`, `DadoEscritoMem`, `EscMem` and `LerMem` with the memory's timing: writes commit at the posedge, reads sample at the negedge. Read data is returned to the datapath as a one-cycle response pulse. It sits between the nRisc datapath/control unit and the data memory.

---
 rtl/controlador_memoria_pkg.sv | 17 +
 rtl/controlador_memoria_if.sv | 50 +++++
 rtl/controlador_memoria_gerador_endereco.sv | 48 ++++
 rtl/controlador_memoria.sv | 132 +++++++++++++
 4 files changed

// File: rtl/controlador_memoria_pkg.sv
// pacote_memoria: shared definitions for the data-memory load/store sequencer.
//   ADDR_W_PADRAO / DATA_W_PADRAO : default address and data widths (256 x 8 memory)
//   TAM_W                         : width of the burst length field (beats minus 1)
//   estado_mem_t                  : sequencer states OCIOSO / LEITURA / ESCRITA
package pacote_memoria;

  localparam int ADDR_W_PADRAO = 8;
  localparam int DATA_W_PADRAO = 8;
  localparam int TAM_W         = 2;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    ESCRITA = 2'd2
  } estado_mem_t;

endpackage

// File: rtl/controlador_memoria_if.sv
// controlador_memoria_if: datapath request/response channel plus data-memory bus.
//   Request  : ReqValido, ReqPronto, ReqEscrita, ReqEndereco, ReqDado, ReqTamanho
//   Response : RespValido, RespDado, Ocupado
//   Memory   : Endereco, DadoEscritoMem, EscMem, LerMem, DadoLido
//   modport slave  : the controller's view
//   modport master : the environment's view (datapath + memory)
// Optional feature macro: MEM_CTRL_RAJADA_EN adds ReqTamanho (burst length - 1).
interface controlador_memoria_if
  import pacote_memoria::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO,
  parameter int DATA_W = DATA_W_PADRAO
);

  logic              ReqValido;
  logic              ReqPronto;
  logic              ReqEscrita;
  logic [ADDR_W-1:0] ReqEndereco;
  logic [DATA_W-1:0] ReqDado;
`ifdef MEM_CTRL_RAJADA_EN
  logic [TAM_W-1:0]  ReqTamanho;
`endif
  logic              RespValido;
  logic [DATA_W-1:0] RespDado;
  logic              Ocupado;
  logic [ADDR_W-1:0] Endereco;
  logic [DATA_W-1:0] DadoEscritoMem;
  logic              EscMem;
  logic              LerMem;
  logic [DATA_W-1:0] DadoLido;

  modport slave (
`ifdef MEM_CTRL_RAJADA_EN
    input  ReqTamanho,
`endif
    input  ReqValido, ReqEscrita, ReqEndereco, ReqDado, DadoLido,
    output ReqPronto, RespValido, RespDado, Ocupado,
    output Endereco, DadoEscritoMem, EscMem, LerMem
  );

  modport master (
`ifdef MEM_CTRL_RAJADA_EN
    output ReqTamanho,
`endif
    output ReqValido, ReqEscrita, ReqEndereco, ReqDado, DadoLido,
    input  ReqPronto, RespValido, RespDado, Ocupado,
    input  Endereco, DadoEscritoMem, EscMem, LerMem
  );

endinterface

// File: rtl/controlador_memoria_gerador_endereco.sv
// gerador_endereco: loadable memory address register with wrapping increment,
// plus the remaining-beats counter of the current transfer.
//   Clock, Reset     : clock, asynchronous active-high reset
//   carregar         : load endereco_inicial / tamanho (acceptance edge)
//   avancar          : step to the next beat (address + 1, counter - 1)
//   endereco_inicial : start address of the transfer
//   tamanho          : beats minus 1
//   endereco         : current memory address
//   ultimo           : current beat is the last one (counter == 0)
module gerador_endereco
  import pacote_memoria::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              carregar,
  input  logic              avancar,
  input  logic [ADDR_W-1:0] endereco_inicial,
  input  logic [TAM_W-1:0]  tamanho,
  output logic [ADDR_W-1:0] endereco,
  output logic              ultimo
);

  logic [ADDR_W-1:0] endereco_r;
  logic [TAM_W-1:0]  restantes_r;

  // Address and beat counter; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      endereco_r  <= {ADDR_W{1'b0}};
      restantes_r <= {TAM_W{1'b0}};
    end else if (carregar) begin
      endereco_r  <= endereco_inicial;
      restantes_r <= tamanho;
    end else if (avancar) begin
      endereco_r  <= endereco_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      restantes_r <= restantes_r - {{(TAM_W-1){1'b0}}, 1'b1};
    end else begin
      endereco_r  <= endereco_r;
      restantes_r <= restantes_r;
    end
  end

  assign endereco = endereco_r;
  assign ultimo   = (restantes_r == {TAM_W{1'b0}});

endmodule

// File: rtl/controlador_memoria.sv
// controlador_memoria: single-initiator load/store sequencer for the data memory.
// Accepts one request at a time over ReqValido/ReqPronto, drives the memory bus
// (writes commit at posedge, reads sampled by the memory at negedge) and returns
// each loaded word as a one-cycle RespValido pulse.
//   Clock, Reset : clock, asynchronous active-high reset
//   bus          : controlador_memoria_if.slave (request, response, memory bus)
// Optional feature macro: MEM_CTRL_RAJADA_EN enables 1-4 beat bursts via ReqTamanho;
// when undefined every request is a single beat.
module controlador_memoria
  import pacote_memoria::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO,
  parameter int DATA_W = DATA_W_PADRAO
) (
  input  logic                  Clock,
  input  logic                  Reset,
  controlador_memoria_if.slave  bus
);

  estado_mem_t       estado_r, estado_nx_s;
  logic              esc_mem_r, esc_mem_nx_s;
  logic              ler_mem_r, ler_mem_nx_s;
  logic              resp_valido_r, resp_valido_nx_s;
  logic [DATA_W-1:0] resp_dado_r, resp_dado_nx_s;
  logic [DATA_W-1:0] dado_esc_r, dado_esc_nx_s;
  logic              carregar_s, avancar_s, ultimo_s;
  logic [TAM_W-1:0]  tamanho_s;
  logic [ADDR_W-1:0] endereco_s;

`ifdef MEM_CTRL_RAJADA_EN
  assign tamanho_s = bus.ReqTamanho;
`else
  assign tamanho_s = {TAM_W{1'b0}};
`endif

  gerador_endereco #(.ADDR_W(ADDR_W)) u_gerador (
    .Clock            (Clock),
    .Reset            (Reset),
    .carregar         (carregar_s),
    .avancar          (avancar_s),
    .endereco_inicial (bus.ReqEndereco),
    .tamanho          (tamanho_s),
    .endereco         (endereco_s),
    .ultimo           (ultimo_s)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    estado_nx_s      = estado_r;
    esc_mem_nx_s     = esc_mem_r;
    ler_mem_nx_s     = ler_mem_r;
    resp_valido_nx_s = 1'b0;
    resp_dado_nx_s   = resp_dado_r;
    dado_esc_nx_s    = dado_esc_r;
    carregar_s       = 1'b0;
    avancar_s        = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (bus.ReqValido) begin
          carregar_s    = 1'b1;
          dado_esc_nx_s = bus.ReqDado;
          if (bus.ReqEscrita) begin
            estado_nx_s  = ESCRITA;
            esc_mem_nx_s = 1'b1;
            ler_mem_nx_s = 1'b0;
          end else begin
            estado_nx_s  = LEITURA;
            esc_mem_nx_s = 1'b0;
            ler_mem_nx_s = 1'b1;
          end
        end else begin
          esc_mem_nx_s = 1'b0;
          ler_mem_nx_s = 1'b0;
        end
      end
      LEITURA: begin
        // The memory drove DadoLido at the preceding negedge; capture it now.
        resp_dado_nx_s   = bus.DadoLido;
        resp_valido_nx_s = 1'b1;
        if (ultimo_s) begin
          ler_mem_nx_s = 1'b0;
          estado_nx_s  = OCIOSO;
        end else begin
          avancar_s = 1'b1;
        end
      end
      ESCRITA: begin
        // The memory commits at this edge using the current address.
        if (ultimo_s) begin
          esc_mem_nx_s = 1'b0;
          estado_nx_s  = OCIOSO;
        end else begin
          avancar_s = 1'b1;
        end
      end
      default: begin
        estado_nx_s  = OCIOSO;
        esc_mem_nx_s = 1'b0;
        ler_mem_nx_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the memory enables immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_r      <= OCIOSO;
      esc_mem_r     <= 1'b0;
      ler_mem_r     <= 1'b0;
      resp_valido_r <= 1'b0;
      resp_dado_r   <= {DATA_W{1'b0}};
      dado_esc_r    <= {DATA_W{1'b0}};
    end else begin
      estado_r      <= estado_nx_s;
      esc_mem_r     <= esc_mem_nx_s;
      ler_mem_r     <= ler_mem_nx_s;
      resp_valido_r <= resp_valido_nx_s;
      resp_dado_r   <= resp_dado_nx_s;
      dado_esc_r    <= dado_esc_nx_s;
    end
  end

  assign bus.ReqPronto      = (estado_r == OCIOSO);
  assign bus.Ocupado        = (estado_r != OCIOSO);
  assign bus.RespValido     = resp_valido_r;
  assign bus.RespDado       = resp_dado_r;
  assign bus.Endereco       = endereco_s;
  assign bus.DadoEscritoMem = dado_esc_r;
  assign bus.EscMem         = esc_mem_r;
  assign bus.LerMem         = ler_mem_r;

endmodule
